// File: rtl/seg_pkg.sv
// Shared types and active-low segment patterns for the seven-segment scan driver.
// Bit order is {a,b,c,d,e,f,g,dp}; a cleared bit lights the segment.
package seg_pkg;

    typedef logic [3:0] digit_t;

    localparam int unsigned SEG_W  = 8;
    localparam int unsigned DP_BIT = 0;

    localparam logic [SEG_W-1:0] SEG_0     = 8'h03;
    localparam logic [SEG_W-1:0] SEG_1     = 8'h9F;
    localparam logic [SEG_W-1:0] SEG_2     = 8'h25;
    localparam logic [SEG_W-1:0] SEG_3     = 8'h0D;
    localparam logic [SEG_W-1:0] SEG_4     = 8'h99;
    localparam logic [SEG_W-1:0] SEG_5     = 8'h49;
    localparam logic [SEG_W-1:0] SEG_6     = 8'h41;
    localparam logic [SEG_W-1:0] SEG_7     = 8'h1F;
    localparam logic [SEG_W-1:0] SEG_8     = 8'h01;
    localparam logic [SEG_W-1:0] SEG_9     = 8'h09;
    localparam logic [SEG_W-1:0] SEG_A     = 8'h11;
    localparam logic [SEG_W-1:0] SEG_B     = 8'hC1;
    localparam logic [SEG_W-1:0] SEG_C     = 8'h63;
    localparam logic [SEG_W-1:0] SEG_D     = 8'h85;
    localparam logic [SEG_W-1:0] SEG_E     = 8'h61;
    localparam logic [SEG_W-1:0] SEG_F     = 8'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/seg_scan_driver_decode.sv
// Combinational 4-bit value to active-low segment pattern (decimal point not driven).
// With hex_en low, values 10..15 render dark.
module seg_decode
    import seg_pkg::*;
(
    input  digit_t             value,
    input  logic               hex_en,
    output logic [SEG_W-1:0]   pattern_c
);

    always_comb begin
        pattern_c = SEG_BLANK;
        case (value)
            4'h0: pattern_c = SEG_0;
            4'h1: pattern_c = SEG_1;
            4'h2: pattern_c = SEG_2;
            4'h3: pattern_c = SEG_3;
            4'h4: pattern_c = SEG_4;
            4'h5: pattern_c = SEG_5;
            4'h6: pattern_c = SEG_6;
            4'h7: pattern_c = SEG_7;
            4'h8: pattern_c = SEG_8;
            4'h9: pattern_c = SEG_9;
            4'hA: pattern_c = hex_en ? SEG_A : SEG_BLANK;
            4'hB: pattern_c = hex_en ? SEG_B : SEG_BLANK;
            4'hC: pattern_c = hex_en ? SEG_C : SEG_BLANK;
            4'hD: pattern_c = hex_en ? SEG_D : SEG_BLANK;
            4'hE: pattern_c = hex_en ? SEG_E : SEG_BLANK;
            4'hF: pattern_c = hex_en ? SEG_F : SEG_BLANK;
            default: pattern_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: one-hot anode scan, shadow-buffered digits,
// leading-zero suppression, per-digit blanking and dead time between slots.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 1,
    parameter bit          HEX_EN       = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [SEG_W-1:0]        cathode,
    output logic                    frame_done
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]               cnt;
    logic [IDX_W-1:0]               idx;

    digit_t [NUM_DIGITS-1:0]        pend_val;
    logic   [NUM_DIGITS-1:0]        pend_dp;
    logic   [NUM_DIGITS-1:0]        pend_mask;
    digit_t [NUM_DIGITS-1:0]        disp_val;
    logic   [NUM_DIGITS-1:0]        disp_dp;
    logic   [NUM_DIGITS-1:0]        disp_mask;

    // Registered wrap so frame_done lines up with digit 0's first output cycle
    logic                           wrap_q;

    logic                           slot_end_c;
    logic                           wrap_c;
    logic                           dead_c;
    logic [NUM_DIGITS-1:0]          supp_c;
    logic                           zero_run_c;
    digit_t                         cur_val_c;
    logic [SEG_W-1:0]               dec_c;
    logic [NUM_DIGITS-1:0]          anode_c;
    logic [SEG_W-1:0]               cathode_c;

    always_comb begin
        slot_end_c = (cnt == CNT_LAST);
        wrap_c     = slot_end_c && (idx == IDX_LAST);
        dead_c     = (BLANK_CYCLES != 0) && (cnt < CNT_DEAD);
        cur_val_c  = disp_val[idx];
    end

    // A digit is a leading zero when it and every more significant digit are zero
    always_comb begin
        zero_run_c = 1'b1;
        supp_c     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run_c = zero_run_c & (disp_val[i] == 4'h0);
            supp_c[i]  = lz_en & zero_run_c & (i != 0);
        end
    end

    seg_decode u_decode (
        .value     (cur_val_c),
        .hex_en    (HEX_EN),
        .pattern_c (dec_c)
    );

    always_comb begin
        anode_c   = '0;
        cathode_c = SEG_BLANK;
        if (!dead_c) begin
            anode_c = NUM_DIGITS'(1) << idx;
            if (!disp_mask[idx]) begin
                cathode_c = supp_c[idx] ? SEG_BLANK : dec_c;
                if (disp_dp[idx]) begin
                    cathode_c[DP_BIT] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_mask  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_mask  <= '0;
            wrap_q     <= 1'b0;
            anode      <= '0;
            cathode    <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            if (slot_end_c) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (load) begin
                pend_val  <= digits;
                pend_dp   <= dp;
                pend_mask <= blank_mask;
            end

            // Display takes the pending value held before this edge, so a load
            // landing on the wrap cycle waits for the following frame
            if (wrap_c) begin
                disp_val  <= pend_val;
                disp_dp   <= pend_dp;
                disp_mask <= pend_mask;
            end

            wrap_q     <= wrap_c;
            frame_done <= wrap_q;
            anode      <= anode_c;
            cathode    <= cathode_c;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (4 digits, 4 cycles per slot, 1 dead cycle), HEX_EN on and off.
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank_mask;
    logic        lz_en;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame_done;
    logic [3:0]  anode_nh;
    logic [7:0]  cathode_nh;
    logic        frame_done_nh;

    int tests  = 0;
    int failed = 0;

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] cat;
        logic [7:0] cat_nh;
        logic       fd;
    } exp_t;

    exp_t sbq[$];

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  mask;
        logic        lz;
        logic [31:0] exp_hex;
        logic [31:0] exp_nh;
    } vec_t;

    vec_t vecs[10];

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .HEX_EN       (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits     (digits),
        .dp         (dp),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .anode      (anode),
        .cathode    (cathode),
        .frame_done (frame_done)
    );

    seg_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (1),
        .HEX_EN       (1'b0)
    ) dut_nh (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .digits     (digits),
        .dp         (dp),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .anode      (anode_nh),
        .cathode    (cathode_nh),
        .frame_done (frame_done_nh)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected 16 output cycles of one frame, digit values packed {d3,d2,d1,d0}
    task automatic push_frame(input logic [31:0] exp_hex, input logic [31:0] exp_nh, input logic fd0);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            int d;
            int c;
            d = k / 4;
            c = k % 4;
            if (c < 1) begin
                e.anode  = 4'b0000;
                e.cat    = 8'hFF;
                e.cat_nh = 8'hFF;
            end else begin
                e.anode  = 4'(1 << d);
                e.cat    = exp_hex[8*d +: 8];
                e.cat_nh = exp_nh[8*d +: 8];
            end
            e.fd = (k == 0) ? fd0 : 1'b0;
            sbq.push_back(e);
        end
    endtask

    // Compare 16 samples against the queue; optionally pulse load at sample load_at
    task automatic check_frame(input string tag, input int load_at, input logic [15:0] ld_val);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            if (sbq.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL %s k=%0d: scoreboard empty", tag, k);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("%s k=%0d anode", tag, k), 32'(anode), 32'(e.anode));
                chk($sformatf("%s k=%0d cathode", tag, k), 32'(cathode), 32'(e.cat));
                chk($sformatf("%s k=%0d anode_nh", tag, k), 32'(anode_nh), 32'(e.anode));
                chk($sformatf("%s k=%0d cathode_nh", tag, k), 32'(cathode_nh), 32'(e.cat_nh));
                chk($sformatf("%s k=%0d frame_done", tag, k), 32'(frame_done), 32'(e.fd));
            end
            if (k == load_at) begin
                load   = 1'b1;
                digits = ld_val;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        chk($sformatf("%s frame_done seen", tag), 32'(seen), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m, input logic lz);
        load       = 1'b1;
        digits     = d;
        dp         = p;
        blank_mask = m;
        lz_en      = lz;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'b0000, 1'b0, 32'h9F250D99, 32'h9F250D99};
        vecs[1] = '{16'hABCD, 4'b0001, 4'b0000, 1'b0, 32'h11C16384, 32'hFFFFFFFE};
        vecs[2] = '{16'hABCD, 4'b0000, 4'b0000, 1'b0, 32'h11C16385, 32'hFFFFFFFF};
        vecs[3] = '{16'h0050, 4'b1000, 4'b0000, 1'b1, 32'hFEFF4903, 32'hFEFF4903};
        vecs[4] = '{16'h0050, 4'b1000, 4'b0000, 1'b0, 32'h02034903, 32'h02034903};
        vecs[5] = '{16'h1234, 4'b0000, 4'b0100, 1'b0, 32'h9FFF0D99, 32'h9FFF0D99};
        vecs[6] = '{16'h0000, 4'b0000, 4'b0000, 1'b1, 32'hFFFFFF03, 32'hFFFFFF03};
        vecs[7] = '{16'h0000, 4'b1111, 4'b0010, 1'b1, 32'hFEFEFF02, 32'hFEFEFF02};
        vecs[8] = '{16'h9876, 4'b0000, 4'b0000, 1'b0, 32'h09011F41, 32'h09011F41};
        vecs[9] = '{16'hEF05, 4'b0000, 4'b0000, 1'b1, 32'h61710349, 32'hFFFF0349};

        clk        = 1'b0;
        rst        = 1'b1;
        load       = 1'b0;
        digits     = '0;
        dp         = '0;
        blank_mask = '0;
        lz_en      = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset%0d anode", i), 32'(anode), 32'h0);
            chk($sformatf("reset%0d cathode", i), 32'(cathode), 32'hFF);
            chk($sformatf("reset%0d frame_done", i), 32'(frame_done), 32'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        push_frame(32'h03030303, 32'h03030303, 1'b0);
        check_frame("post_reset", -1, 16'h0);
        chk("post_reset wrap pulse", 32'(frame_done), 32'd1);

        // Table-driven frames: load early in a frame, check the whole next frame
        foreach (vecs[v]) begin
            do_load(vecs[v].digits, vecs[v].dp, vecs[v].mask, vecs[v].lz);
            wait_frame($sformatf("vec%0d", v));
            push_frame(vecs[v].exp_hex, vecs[v].exp_nh, 1'b1);
            check_frame($sformatf("vec%0d", v), -1, 16'h0);
            chk($sformatf("vec%0d period 16", v), 32'(frame_done), 32'd1);
        end

        // Tear-free: mid-frame load at idx 2 does not disturb the current frame
        do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
        wait_frame("tear");
        push_frame(32'h9F9F9F9F, 32'h9F9F9F9F, 1'b1);
        check_frame("tear_cur", 8, 16'h2222);
        push_frame(32'h25252525, 32'h25252525, 1'b1);
        check_frame("tear_next", 14, 16'h3333);
        push_frame(32'h25252525, 32'h25252525, 1'b1);
        check_frame("wrap_deferred", -1, 16'h0);
        push_frame(32'h0D0D0D0D, 32'h0D0D0D0D, 1'b1);
        check_frame("wrap_applied", -1, 16'h0);

        // Mid-frame reset at idx 2 discards a pending load
        chk("pre_rst frame_done", 32'(frame_done), 32'd1);
        do_load(16'h5555, 4'b1111, 4'b0000, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst anode", 32'(anode), 32'h0);
        chk("midrst cathode", 32'(cathode), 32'hFF);
        chk("midrst cathode_nh", 32'(cathode_nh), 32'hFF);
        chk("midrst frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        push_frame(32'h03030303, 32'h03030303, 1'b0);
        check_frame("after_rst", -1, 16'h0);
        push_frame(32'h03030303, 32'h03030303, 1'b1);
        check_frame("pending_discarded", -1, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver for N common-anode digits on one shared active-low cathode bus. Each cycle it scans one digit position with a one-hot active-high anode and decodes that digit's 4-bit value (BCD or hex) plus decimal point onto the cathodes. It adds shadow-buffered tear-free updates, leading-zero suppression, per-digit blanking and anti-ghost dead time. It sits between the application's numeric outputs and the board's anode/cathode pins.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits (2..8)
- REFRESH_DIV, 100000, clock cycles per digit slot (≥ 2)
- BLANK_CYCLES, 1, dead-time cycles at start of each slot (0 ≤ BLANK_CYCLES < REFRESH_DIV)
- HEX_EN, 1, 1 = decode 10–15 as A,b,C,d,E,F; 0 = values 10–15 render blank
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle strobe: capture digits/dp/blank_mask into pending buffer
- digits  in  4*NUM_DIGITS  packed values; digit i = digits[4i+3:4i], digit 0 rightmost
- dp  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_mask  in  NUM_DIGITS  1 = digit forced dark (dp included)
- lz_en  in  1  leading-zero suppression enable (live, not buffered)
- anode  out  NUM_DIGITS  one-hot active-high digit select, all-zero while blanked
- cathode  out  8  active-low {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp
- frame_done  out  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to 0

## Operation
- Slot counter cnt: 0..REFRESH_DIV-1. Digit index idx: 0..NUM_DIGITS-1. idx increments when cnt = REFRESH_DIV-1 and wraps to 0.
- Dead time: while cnt < BLANK_CYCLES, anode = 0 and cathode = 8'hFF.
- Otherwise anode = 1 << idx and cathode = decode(display[idx]), with bit 0 cleared if dp[idx].
- Decode values 0–9: 03,9F,25,0D,99,49,41,1F,01,09 (hex). HEX_EN=1 values 10–15: 11,C1,63,85,61,71. HEX_EN=0 values 10–15: FF.
- Double buffering:
  - load copies inputs into the pending registers.
  - Pending is copied into the display registers on the wrap cycle (idx = NUM_DIGITS-1, cnt = REFRESH_DIV-1), the same cycle that raises frame_done.
  - load on the wrap cycle: the new data enters pending only and is displayed from the following frame.
  - Multiple loads within a frame: last load wins.
- Blanking: blank_mask[idx] = 1 gives segments 8'hFF, dp off, anode still asserted.
- Leading zero suppression (lz_en = 1):
  - Digit i is suppressed if display[j] = 0 for all j ≥ i.
  - Digit 0 is never suppressed.
  - Suppressed digits render 8'hFF but still show dp if set.
- Reset values: cnt 0, idx 0, pending and display all 0 (values, dp, mask), anode 0, cathode 8'hFF, frame_done 0.
- rst mid-frame aborts the scan, discards pending, and restarts at digit 0 with the reset values above.

## Timing
- anode, cathode and frame_done are registered: they reflect the cnt/idx/display state of the previous cycle. Latency is 1 cycle.
- Under steady scan each digit is lit REFRESH_DIV-BLANK_CYCLES cycles per slot.
- Frame length is NUM_DIGITS*REFRESH_DIV cycles.
- The earliest visibility of a load is the first non-blank output of digit 0 in the next frame.
- frame_done is high for exactly one cycle per frame, aligned with the first dead-time output of digit 0.

## Structure
- Package seg_pkg: 8-bit segment constants SEG_0..SEG_F, SEG_BLANK = 8'hFF, the DP bit index, and a digit-value typedef (logic [3:0]).
- Sub-module seg_decode: combinational (value, hex_en) → 8-bit active-low pattern, no dp. Instantiated once on the muxed digit.
- Top module holds the counters, pending/display buffers, suppression logic and output registers. Counter widths are $clog2(REFRESH_DIV) and $clog2(NUM_DIGITS).

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.
- Reset: hold rst 3 cycles, release → anode=0000, cathode=FF after reset. anode=0001 from the 2nd edge after release for 3 cycles, then 0000 for 1 cycle, then 0010.
- Scan and decode: load digits=16'h1234, dp=0 → from the next frame, digit 0 shows 99, digit 1 shows 0D, digit 2 shows 25, digit 3 shows 9F. frame_done pulses every 16 cycles.
- Hex and dp: HEX_EN=1, digits=16'hABCD, dp=4'b0001 → digit 0 (D) = 84, digit 3 (A) = 11. Rerun with HEX_EN=0 → all four digits = FF.
- Leading zeros: digits=16'h0050, dp=4'b1000, lz_en=1 → digit 3 = FE, digit 2 = FF, digit 1 = 49, digit 0 = 03. lz_en=0 → digit 3 = 02, digit 2 = 03.
- Tear-free update: load 16'h1111, then pulse load 16'h2222 at idx=2 mid-frame → the rest of the current frame still shows 9F. The next frame shows 25 on all digits. A load on the wrap cycle is deferred one further frame.
- Mask and mid-frame reset: blank_mask=4'b0100 → digit 2 gives anode=0100, cathode=FF. Assert rst at idx=2 → outputs return to reset values next cycle and digit 0 data reads 03.
